// File: rtl/eth_axis_rx_packer.sv
// AXI-Stream width upsizer for the Ethernet RX path: packs IN_W-bit beats
// little-endian into IN_W*RATIO-bit words and queues them in a FWFT FIFO.
module eth_axis_rx_packer #(
  parameter int unsigned IN_W        = 8,
  parameter int unsigned RATIO       = 4,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned TUSER_FRAME = 0
) (
  input  logic                         s_clk_i,
  input  logic                         s_rstn_i,
  input  logic [IN_W-1:0]              s_axis_tdata,
  input  logic                         s_axis_tvalid,
  input  logic                         s_axis_tuser,
  input  logic                         s_axis_tlast,
  output logic                         s_axis_tready,
  output logic [IN_W*RATIO-1:0]        m_axis_tdata,
  output logic [$clog2(RATIO)-1:0]     m_axis_byte_count,
  output logic                         m_axis_tvalid,
  output logic                         m_axis_tuser,
  output logic                         m_axis_tlast,
  input  logic                         m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level_o
);

  localparam int unsigned OUT_W  = IN_W * RATIO;
  localparam int unsigned LANE_W = $clog2(RATIO);
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned LVL_W  = $clog2(DEPTH + 1);
  localparam logic        FRAME_MODE = (TUSER_FRAME != 0);

  typedef struct packed {
    logic              user;
    logic              last;
    logic [LANE_W-1:0] bc;
    logic [OUT_W-1:0]  data;
  } word_t;

  // Packing state
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic              acc_user_q, acc_user_d;
  logic              sticky_q, sticky_d;

  // FIFO state; head_q is the registered copy of the entry at rd_ptr_q
  word_t             mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  word_t             head_q, head_d;
  logic              head_vld_q, head_vld_d;

  logic              accept;
  logic              commit;
  logic              pop;
  logic [OUT_W-1:0]  merged;
  word_t             push_word;

  // Beat placement, word assembly and tuser accumulation
  always_comb begin
    accept     = s_axis_tvalid & ~full_q;
    commit     = accept & ((lane_q == LANE_W'(RATIO - 1)) | s_axis_tlast);

    merged = acc_q;
    for (int unsigned k = 0; k < RATIO; k++) begin
      if (lane_q == LANE_W'(k)) begin
        merged[IN_W*k +: IN_W] = s_axis_tdata;
      end
    end

    push_word.data = merged;
    push_word.bc   = lane_q;
    push_word.last = s_axis_tlast;
    push_word.user = acc_user_q | s_axis_tuser |
                     (FRAME_MODE & s_axis_tlast & sticky_q);

    lane_d     = lane_q;
    acc_d      = acc_q;
    acc_user_d = acc_user_q;
    sticky_d   = sticky_q;

    if (accept) begin
      if (commit) begin
        lane_d     = '0;
        acc_d      = '0;
        acc_user_d = 1'b0;
      end else begin
        lane_d     = lane_q + LANE_W'(1);
        acc_d      = merged;
        acc_user_d = acc_user_q | s_axis_tuser;
      end
      sticky_d = s_axis_tlast ? 1'b0 : (sticky_q | s_axis_tuser);
    end
  end

  // FIFO pointer/level update and next head selection
  always_comb begin
    pop = head_vld_q & m_axis_tready;

    wr_ptr_d   = wr_ptr_q + PTR_W'(commit);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    level_d    = level_q + LVL_W'(commit) - LVL_W'(pop);
    full_d     = (level_d == LVL_W'(DEPTH));
    head_vld_d = (level_d != '0);
    head_d     = head_q;

    if (level_d != '0) begin
      if (commit && (wr_ptr_q == rd_ptr_d)) begin
        head_d = push_word;
      end else begin
        head_d = mem[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge s_clk_i or negedge s_rstn_i) begin
    if (!s_rstn_i) begin
      lane_q     <= '0;
      acc_q      <= '0;
      acc_user_q <= 1'b0;
      sticky_q   <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      head_q     <= '0;
      head_vld_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      acc_q      <= acc_d;
      acc_user_q <= acc_user_d;
      sticky_q   <= sticky_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by the pointers alone
  always_ff @(posedge s_clk_i) begin
    if (commit) begin
      mem[wr_ptr_q] <= push_word;
    end
  end

  assign s_axis_tready     = ~full_q;
  assign m_axis_tvalid     = head_vld_q;
  assign m_axis_tdata      = head_q.data;
  assign m_axis_byte_count = head_q.bc;
  assign m_axis_tlast      = head_q.last;
  assign m_axis_tuser      = head_q.user;
  assign fifo_level_o      = level_q;

endmodule

// File: tb/tb_eth_axis_rx_packer.sv
// Directed and randomised checks of eth_axis_rx_packer in three configurations.
module tb_eth_axis_rx_packer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Shared stimulus for instances A (TUSER_FRAME=0) and B (TUSER_FRAME=1)
  logic [7:0]  s_tdata;
  logic        s_tvalid, s_tuser, s_tlast, m_tready;

  logic        a_s_tready, a_m_tvalid, a_m_tuser, a_m_tlast;
  logic [31:0] a_m_tdata;
  logic [1:0]  a_m_bc;
  logic [2:0]  a_level;

  logic        b_s_tready, b_m_tvalid, b_m_tuser, b_m_tlast;
  logic [31:0] b_m_tdata;
  logic [1:0]  b_m_bc;
  logic [2:0]  b_level;

  // Instance C: IN_W=16, RATIO=2
  logic [15:0] c_s_tdata;
  logic        c_s_tvalid, c_s_tuser, c_s_tlast, c_s_tready;
  logic [31:0] c_m_tdata;
  logic [0:0]  c_m_bc;
  logic        c_m_tvalid, c_m_tuser, c_m_tlast, c_m_tready;
  logic [2:0]  c_level;

  eth_axis_rx_packer #(.IN_W(8), .RATIO(4), .DEPTH(4), .TUSER_FRAME(0)) u_a (
    .s_clk_i(clk), .s_rstn_i(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(a_s_tready),
    .m_axis_tdata(a_m_tdata), .m_axis_byte_count(a_m_bc), .m_axis_tvalid(a_m_tvalid),
    .m_axis_tuser(a_m_tuser), .m_axis_tlast(a_m_tlast), .m_axis_tready(m_tready),
    .fifo_level_o(a_level)
  );

  eth_axis_rx_packer #(.IN_W(8), .RATIO(4), .DEPTH(4), .TUSER_FRAME(1)) u_b (
    .s_clk_i(clk), .s_rstn_i(rst_n),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tuser(s_tuser),
    .s_axis_tlast(s_tlast), .s_axis_tready(b_s_tready),
    .m_axis_tdata(b_m_tdata), .m_axis_byte_count(b_m_bc), .m_axis_tvalid(b_m_tvalid),
    .m_axis_tuser(b_m_tuser), .m_axis_tlast(b_m_tlast), .m_axis_tready(m_tready),
    .fifo_level_o(b_level)
  );

  eth_axis_rx_packer #(.IN_W(16), .RATIO(2), .DEPTH(4), .TUSER_FRAME(0)) u_c (
    .s_clk_i(clk), .s_rstn_i(rst_n),
    .s_axis_tdata(c_s_tdata), .s_axis_tvalid(c_s_tvalid), .s_axis_tuser(c_s_tuser),
    .s_axis_tlast(c_s_tlast), .s_axis_tready(c_s_tready),
    .m_axis_tdata(c_m_tdata), .m_axis_byte_count(c_m_bc), .m_axis_tvalid(c_m_tvalid),
    .m_axis_tuser(c_m_tuser), .m_axis_tlast(c_m_tlast), .m_axis_tready(c_m_tready),
    .fifo_level_o(c_level)
  );

  int n_checks = 0;
  int n_errors = 0;
  int c_words  = 0;
  int c_exp_words = 0;
  logic c_done = 1'b0;
  logic [63:0] qa[$];
  logic [63:0] qb[$];
  logic [63:0] cexp[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input logic [31:0] d, input logic [1:0] bc,
                                     input logic last, input logic user);
    return {28'd0, user, last, bc, d};
  endfunction

  // Record completed output handshakes; inputs only change just after posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_m_tvalid && m_tready) qa.push_back(mk(a_m_tdata, a_m_bc, a_m_tlast, a_m_tuser));
      if (b_m_tvalid && m_tready) qb.push_back(mk(b_m_tdata, b_m_bc, b_m_tlast, b_m_tuser));
      if (c_m_tvalid && c_m_tready) begin
        c_words++;
        if (cexp.size() != 0)
          check("c_word", mk(c_m_tdata, {1'b0, c_m_bc}, c_m_tlast, c_m_tuser), cexp.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] d, input logic last, input logic user);
    s_tdata = d; s_tvalid = 1'b1; s_tlast = last; s_tuser = user;
    for (int i = 0; i < 200; i++) begin
      if (a_s_tready && b_s_tready) begin
        tick(1);
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        return;
      end
      tick(1);
    end
    check("send_timeout", 64'(a_s_tready & b_s_tready), 64'd1);
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  task automatic c_send(input logic [15:0] d, input logic last, input logic user);
    c_s_tdata = d; c_s_tvalid = 1'b1; c_s_tlast = last; c_s_tuser = user;
    for (int i = 0; i < 400; i++) begin
      if (c_s_tready) begin
        tick(1);
        c_s_tvalid = 1'b0; c_s_tlast = 1'b0; c_s_tuser = 1'b0;
        return;
      end
      tick(1);
    end
    check("c_send_timeout", 64'(c_s_tready), 64'd1);
    c_s_tvalid = 1'b0; c_s_tlast = 1'b0; c_s_tuser = 1'b0;
  endtask

  task automatic expect_a(input string tag, input logic [63:0] exp);
    if (qa.size() != 0) check(tag, qa.pop_front(), exp);
  endtask

  task automatic expect_b(input string tag, input logic [63:0] exp);
    if (qb.size() != 0) check(tag, qb.pop_front(), exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not finish, %0d checks done", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] beats [8];
    logic        users [8];
    logic [31:0] d;
    logic [1:0]  bc;
    logic        u;
    int          len;

    s_tdata = '0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; m_tready = 1'b1;
    c_s_tdata = '0; c_s_tvalid = 1'b0; c_s_tuser = 1'b0; c_s_tlast = 1'b0; c_m_tready = 1'b1;
    rst_n = 1'b0;

    // Reset values
    tick(2);
    check("rst_tvalid", 64'(a_m_tvalid), 64'd0);
    check("rst_tdata",  64'(a_m_tdata),  64'd0);
    check("rst_bc",     64'(a_m_bc),     64'd0);
    check("rst_tlast",  64'(a_m_tlast),  64'd0);
    check("rst_tuser",  64'(a_m_tuser),  64'd0);
    check("rst_level",  64'(a_level),    64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(1);
    check("rst_tready", 64'(a_s_tready), 64'd1);

    // Test 1: two full words, latency of one cycle
    qa.delete();
    for (int i = 1; i <= 8; i++) begin
      send(8'(i), i == 8, 1'b0);
      if (i == 3) check("t1_no_early_valid", 64'(a_m_tvalid), 64'd0);
      if (i == 4) begin
        check("t1_w0_valid", 64'(a_m_tvalid), 64'd1);
        check("t1_w0", mk(a_m_tdata, a_m_bc, a_m_tlast, a_m_tuser), mk(32'h04030201, 2'd3, 1'b0, 1'b0));
      end
      if (i == 8) begin
        check("t1_w1_valid", 64'(a_m_tvalid), 64'd1);
        check("t1_w1", mk(a_m_tdata, a_m_bc, a_m_tlast, a_m_tuser), mk(32'h08070605, 2'd3, 1'b1, 1'b0));
      end
    end
    tick(3);
    check("t1_count", 64'(qa.size()), 64'd2);

    // Test 2: partial word at frame end, then a single-beat frame
    qa.delete();
    for (int i = 0; i < 6; i++) send(8'(8'hA0 + i), i == 5, 1'b0);
    send(8'h55, 1'b1, 1'b0);
    tick(4);
    check("t2_count", 64'(qa.size()), 64'd3);
    expect_a("t2_w0", mk(32'hA3A2A1A0, 2'd3, 1'b0, 1'b0));
    expect_a("t2_w1", mk(32'h0000A5A4, 2'd1, 1'b1, 1'b0));
    expect_a("t2_w2", mk(32'h00000055, 2'd0, 1'b1, 1'b0));
    check("t2_level", 64'(a_level), 64'd0);

    // Test 3: downstream backpressure fills the FIFO
    qa.delete();
    m_tready = 1'b0;
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b0);
    check("t3_tready_low", 64'(a_s_tready), 64'd0);
    check("t3_level_full", 64'(a_level), 64'd4);
    s_tdata = 8'd16; s_tvalid = 1'b1;
    tick(3);
    check("t3_level_hold", 64'(a_level), 64'd4);
    check("t3_head_hold", 64'(a_m_tdata), 64'h03020100);
    m_tready = 1'b1;
    for (int i = 16; i < 20; i++) send(8'(i), i == 19, 1'b0);
    tick(10);
    check("t3_count", 64'(qa.size()), 64'd5);
    for (int w = 0; w < 5; w++)
      expect_a("t3_word", mk({8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)}, 2'd3, w == 4, 1'b0));

    // Test 4: per-word versus frame-sticky tuser
    qa.delete(); qb.delete();
    for (int i = 0; i < 8; i++) send(8'(8'h10 + i), i == 7, i == 2);
    for (int i = 0; i < 8; i++) send(8'(8'h20 + i), i == 7, 1'b0);
    tick(4);
    check("t4_a_count", 64'(qa.size()), 64'd4);
    check("t4_b_count", 64'(qb.size()), 64'd4);
    expect_a("t4_a_w0", mk(32'h13121110, 2'd3, 1'b0, 1'b1));
    expect_a("t4_a_w1", mk(32'h17161514, 2'd3, 1'b1, 1'b0));
    expect_a("t4_a_w2", mk(32'h23222120, 2'd3, 1'b0, 1'b0));
    expect_a("t4_a_w3", mk(32'h27262524, 2'd3, 1'b1, 1'b0));
    expect_b("t4_b_w0", mk(32'h13121110, 2'd3, 1'b0, 1'b1));
    expect_b("t4_b_w1", mk(32'h17161514, 2'd3, 1'b1, 1'b1));
    expect_b("t4_b_w2", mk(32'h23222120, 2'd3, 1'b0, 1'b0));
    expect_b("t4_b_w3", mk(32'h27262524, 2'd3, 1'b1, 1'b0));

    // Test 5: asynchronous reset with a queued word and a partial word
    m_tready = 1'b0;
    for (int i = 0; i < 7; i++) send(8'(8'h30 + i), 1'b0, 1'b0);
    check("t5_level_pre", 64'(a_level), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_tvalid", 64'(a_m_tvalid), 64'd0);
    check("t5_level",  64'(a_level),    64'd0);
    check("t5_b_level", 64'(b_level),   64'd0);
    check("t5_tdata",  64'(a_m_tdata),  64'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    m_tready = 1'b1;
    tick(1);
    qa.delete(); qb.delete();
    send(8'h77, 1'b1, 1'b0);
    check("t5_post_valid", 64'(a_m_tvalid), 64'd1);
    check("t5_post_word", mk(a_m_tdata, a_m_bc, a_m_tlast, a_m_tuser), mk(32'h00000077, 2'd0, 1'b1, 1'b0));
    tick(3);

    // Test 6: IN_W=16/RATIO=2 with random gaps and random downstream stalls
    fork
      begin
        for (int f = 0; f < 1000; f++) begin
          len = $urandom_range(1, 7);
          for (int j = 0; j < len; j++) begin
            beats[j] = 16'($urandom);
            users[j] = ($urandom_range(0, 7) == 0);
          end
          for (int j = 0; j < len; j += 2) begin
            d = {16'd0, beats[j]}; bc = 2'd0; u = users[j];
            if (j + 1 < len) begin
              d[31:16] = beats[j+1]; bc = 2'd1; u = u | users[j+1];
            end
            cexp.push_back(mk(d, bc, j + 2 >= len, u));
            c_exp_words++;
          end
          for (int j = 0; j < len; j++) begin
            tick($urandom_range(0, 2));
            c_send(beats[j], j == len - 1, users[j]);
          end
        end
        c_done = 1'b1;
      end
      begin
        while (!c_done) begin
          c_m_tready = ($urandom_range(0, 3) != 0);
          tick(1);
        end
        c_m_tready = 1'b1;
      end
    join
    for (int i = 0; i < 200; i++) begin
      if (cexp.size() == 0) break;
      tick(1);
    end
    tick(2);
    check("c_word_count", 64'(c_words), 64'(c_exp_words));
    check("c_left_over", 64'(cexp.size()), 64'd0);
    check("c_level_end", 64'(c_level), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
